// File: rtl/bcd_timer_n.sv
// ---------------------------------------------------------------------------
// bcd_timer_n
//   N-digit BCD timer/stopwatch with an internal prescaler, up/down counting,
//   preset (limit or start value), stop-at-end or auto-reload, and a
//   run/pause/resume FSM. One seven-segment digit is driven per BCD digit.
//
// Parameters
//   DIGITS         number of BCD digits (1..8)
//   DIV            clk cycles per count tick (>=1)
//   SEG_ACTIVE_LOW 1 = segment outputs inverted (common-anode board)
//
// Ports
//   clk          system clock, all logic on posedge
//   reset        synchronous, active-high, highest priority
//   start        level: starts from IDLE/DONE, resumes from PAUSED
//   pause        level: freezes the count while high; overrides start
//   dir          0 = count up 0 -> preset, 1 = count down preset -> 0
//   auto_reload  1 = wrap to initial value at terminal, 0 = stop in DONE
//   preset       BCD limit/start value, digit 0 in [3:0]
//   bcd          current count, BCD
//   seg          per-digit segments {g,f,e,d,c,b,a}, digit 0 in [6:0]
//   running      high in RUN
//   done         one-clk pulse per terminal-count event
//   finished     high in DONE
//
// Control semantics: start and pause are plain levels sampled on every
// rising clk edge, with no handshake. Within one cycle reset wins over
// pause, and pause wins over start.
// ---------------------------------------------------------------------------
module bcd_timer_n #(
  parameter int DIGITS         = 2,
  parameter int DIV            = 50000000,
  parameter bit SEG_ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                pause,
  input  logic                dir,
  input  logic                auto_reload,
  input  logic [4*DIGITS-1:0] preset,
  output logic [4*DIGITS-1:0] bcd,
  output logic [7*DIGITS-1:0] seg,
  output logic                running,
  output logic                done,
  output logic                finished
);

  localparam int            BW      = 4 * DIGITS;
  localparam int            PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSED,
    S_DONE
  } state_t;

  state_t        state;
  logic [PW-1:0] prescaler;
  logic [BW-1:0] preset_l;
  logic          dir_l;

  // Any digit above 9 is forced to 9 so bcd can never hold a non-BCD digit.
  function automatic logic [BW-1:0] clamp_bcd(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] bcd_dec(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  logic [BW-1:0] preset_clamped;
  logic          tick;
  logic          at_terminal;
  logic [BW-1:0] init_val;

  assign preset_clamped = clamp_bcd(preset);
  assign tick           = (prescaler == PS_LAST);
  // The terminal value is displayed for a full tick period; the event fires
  // on the tick that would otherwise move past it.
  assign at_terminal    = dir_l ? (bcd == '0) : (bcd == preset_l);
  assign init_val       = dir_l ? preset_l : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      bcd       <= '0;
      prescaler <= '0;
      preset_l  <= '0;
      dir_l     <= 1'b0;
      done      <= 1'b0;
      running   <= 1'b0;
      finished  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start && !pause) begin
            preset_l  <= preset_clamped;
            dir_l     <= dir;
            prescaler <= '0;
            bcd       <= dir ? preset_clamped : '0;
            state     <= S_RUN;
            running   <= 1'b1;
            finished  <= 1'b0;
          end
        end
        S_RUN: begin
          if (pause) begin
            state   <= S_PAUSED;
            running <= 1'b0;
          end else if (tick) begin
            prescaler <= '0;
            if (at_terminal) begin
              done <= 1'b1;
              if (auto_reload) begin
                bcd <= init_val;
              end else begin
                state    <= S_DONE;
                running  <= 1'b0;
                finished <= 1'b1;
              end
            end else begin
              bcd <= dir_l ? bcd_dec(bcd) : bcd_inc(bcd);
            end
          end else begin
            prescaler <= prescaler + 1'b1;
          end
        end
        S_PAUSED: begin
          // Resume keeps the held prescaler phase and count.
          if (start && !pause) begin
            state   <= S_RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          running  <= 1'b0;
          finished <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    seg = '0;
    for (int i = 0; i < DIGITS; i++) begin
      seg[7*i +: 7] = seg_pattern(bcd[4*i +: 4]) ^ {7{SEG_ACTIVE_LOW}};
    end
  end

endmodule

// File: tb/tb_bcd_timer_n.sv
module tb_bcd_timer_n;

  localparam int DIGITS = 2;
  localparam int DIV    = 4;
  localparam bit SEG_AL = 1'b0;
  localparam int BW     = 4 * DIGITS;
  localparam int SW     = 7 * DIGITS;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          dir = 1'b0;
  logic          auto_reload = 1'b0;
  logic [BW-1:0] preset = '0;
  logic [BW-1:0] bcd;
  logic [SW-1:0] seg;
  logic          running;
  logic          done;
  logic          finished;

  always #5 clk = ~clk;

  bcd_timer_n #(
    .DIGITS(DIGITS),
    .DIV(DIV),
    .SEG_ACTIVE_LOW(SEG_AL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .pause(pause),
    .dir(dir),
    .auto_reload(auto_reload),
    .preset(preset),
    .bcd(bcd),
    .seg(seg),
    .running(running),
    .done(done),
    .finished(finished)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_tests    = 0;
  int n_fail     = 0;
  int done_seen  = 0;
  bit chk_en     = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The count is kept as a plain integer; BCD and segments are derived from it.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
  int m_st   = M_IDLE;
  int m_cnt  = 0;
  int m_ps   = 0;
  int m_lim  = 0;
  bit m_down = 1'b0;
  bit m_done = 1'b0;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic int clamp_val(input logic [BW-1:0] p);
    int v = 0;
    int w = 1;
    for (int i = 0; i < DIGITS; i++) begin
      int d;
      d = int'(p[4*i +: 4]);
      if (d > 9) d = 9;
      v += d * w;
      w *= 10;
    end
    return v;
  endfunction

  function automatic logic [BW-1:0] to_bcd(input int v);
    logic [BW-1:0] r = '0;
    int x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [SW-1:0] exp_seg(input int v);
    logic [SW-1:0] r = '0;
    int x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[7*i +: 7] = SEG_AL ? ~seg_tab[x % 10] : seg_tab[x % 10];
      x = x / 10;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    m_done = 1'b0;
    if (reset) begin
      m_st  = M_IDLE;
      m_cnt = 0;
      m_ps  = 0;
    end else if (m_st == M_RUN) begin
      if (pause) begin
        m_st = M_PAUSED;
      end else if (m_ps == DIV - 1) begin
        m_ps = 0;
        if (m_down ? (m_cnt == 0) : (m_cnt == m_lim)) begin
          m_done = 1'b1;
          if (auto_reload) m_cnt = m_down ? m_lim : 0;
          else             m_st  = M_DONE;
        end else begin
          m_cnt = m_down ? m_cnt - 1 : m_cnt + 1;
        end
      end else begin
        m_ps++;
      end
    end else if (start && !pause) begin
      if (m_st == M_PAUSED) begin
        m_st = M_RUN;
      end else begin
        m_lim  = clamp_val(preset);
        m_down = dir;
        m_ps   = 0;
        m_cnt  = m_down ? m_lim : 0;
        m_st   = M_RUN;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("bcd",      32'(bcd),      32'(to_bcd(m_cnt)));
      chk("seg",      32'(seg),      32'(exp_seg(m_cnt)));
      chk("running",  32'(running),  32'(m_st == M_RUN));
      chk("finished", 32'(finished), 32'(m_st == M_DONE));
      chk("done",     32'(done),     32'(m_done));
      if (done === 1'b1) done_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Returns on the negedge just after the start edge (count phase k = 0).
  task automatic start_run(input logic [BW-1:0] p, input logic d, input logic ar);
    @(negedge clk);
    preset      = p;
    dir         = d;
    auto_reload = ar;
    pause       = 1'b0;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0;

    // Reset state
    wait_neg(2);
    chk_en = 1'b1;
    chk("rst_bcd",      32'(bcd),      32'h00);
    chk("rst_seg",      32'(seg),      32'({7'h3F, 7'h3F}));
    chk("rst_running",  32'(running),  32'd0);
    chk("rst_finished", 32'(finished), 32'd0);
    chk("rst_done",     32'(done),     32'd0);
    reset = 1'b0;

    // Up, stop at 12
    d0 = done_seen;
    start_run(8'h12, 1'b0, 1'b0);
    chk("up_first", 32'(bcd), 32'h00);
    wait_neg(40);
    chk("up_carry_10", 32'(bcd), 32'h10);
    wait_neg(16);
    chk("up_hold_12",     32'(bcd),           32'h12);
    chk("up_finished",    32'(finished),      32'd1);
    chk("up_not_running", 32'(running),       32'd0);
    chk("up_done_once",   32'(done_seen - d0), 32'd1);

    // Down with reload from 20
    do_reset();
    start_run(8'h20, 1'b1, 1'b1);
    chk("dn_first", 32'(bcd), 32'h20);
    wait_neg(4);
    chk("dn_borrow_19", 32'(bcd), 32'h19);
    wait_neg(76);
    chk("dn_zero", 32'(bcd), 32'h00);
    wait_neg(4);
    chk("dn_reload_20",  32'(bcd),     32'h20);
    chk("dn_done_pulse", 32'(done),    32'd1);
    chk("dn_running",    32'(running), 32'd1);

    // Pause at 05 with prescaler mid-count, then resume
    do_reset();
    start_run(8'h30, 1'b0, 1'b0);
    wait_neg(22);
    pause = 1'b1;
    wait_neg(10);
    chk("pz_hold_05",   32'(bcd),     32'h05);
    chk("pz_not_run",   32'(running), 32'd0);
    pause = 1'b0;
    start = 1'b1;
    wait_neg(1);
    start = 1'b0;
    chk("pz_resumed",   32'(running), 32'd1);
    wait_neg(1);
    chk("pz_still_05",  32'(bcd),     32'h05);
    wait_neg(1);
    chk("pz_next_06",   32'(bcd),     32'h06);

    // preset = 0, up: done on the first tick
    do_reset();
    start_run(8'h00, 1'b0, 1'b0);
    wait_neg(3);
    chk("p0_no_done_yet", 32'(done), 32'd0);
    wait_neg(1);
    chk("p0_done",     32'(done),     32'd1);
    chk("p0_finished", 32'(finished), 32'd1);
    chk("p0_bcd",      32'(bcd),      32'h00);

    // Restart from DONE with an out-of-range preset digit, down mode
    start_run(8'h9F, 1'b1, 1'b0);
    chk("clamp_99",       32'(bcd),      32'h99);
    chk("clamp_running",  32'(running),  32'd1);
    chk("clamp_finished", 32'(finished), 32'd0);

    // start and pause together in IDLE
    do_reset();
    @(negedge clk);
    start = 1'b1;
    pause = 1'b1;
    wait_neg(1);
    chk("sp_idle_running", 32'(running), 32'd0);
    chk("sp_idle_bcd",     32'(bcd),     32'h00);
    start = 1'b0;
    pause = 1'b0;

    // Reset on the same edge as a terminal tick
    start_run(8'h02, 1'b0, 1'b0);
    wait_neg(11);
    chk("rt_at_02", 32'(bcd), 32'h02);
    reset = 1'b1;
    wait_neg(1);
    chk("rt_no_done", 32'(done),    32'd0);
    chk("rt_bcd",     32'(bcd),     32'h00);
    chk("rt_idle",    32'(running), 32'd0);
    reset = 1'b0;

    // Randomised stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 7) == 0);
      pause = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 15) == 0) begin
        dir         = 1'($urandom_range(0, 1));
        auto_reload = 1'($urandom_range(0, 1));
        preset      = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
      end
    end
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    wait_neg(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
